sha256_msg_sched: RTL and testbench

Sequential SHA-256 message-schedule generator. It sits directly upstream of the compression stage (sha_main datapath).
- Accepts one padded 512-bit block.
- Emits the 64 schedule words W[0..63] in order, one per accepted handshake.
- Uses a 16-word sliding window, not a 64-word array.
- The downstream compressor consumes W[t] in round t and can stall the stream through w_ready.

---
 rtl/sha256_msg_sched.sv | 114 +++++++++++
 tb/tb_sha256_msg_sched.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_sched.sv
// SHA-256 message-schedule generator.
// Takes one padded 512-bit block and streams W[0..NUM_ROUNDS-1] through a
// valid/ready port. A 16-word sliding window holds W[t..t+15]. Each accepted
// word shifts the window down by one and appends W[t+16].
//
// Handshake rules: a transfer happens on a rising clock edge where valid and
// ready are both high. A producer holding valid high keeps its payload stable
// until that transfer. Ready may change freely, and valid never depends on
// ready within the same cycle.
//
// The FSM state is visible through busy (high in RUN, low in IDLE).
module sha256_msg_sched #(
  parameter int NUM_ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  output logic         w_valid,
  input  logic         w_ready,
  output logic [31:0]  w_data,
  output logic [5:0]   w_idx,
  output logic         w_last,
  output logic         busy
);

  localparam logic       IDLE     = 1'b0;
  localparam logic       RUN      = 1'b1;
  localparam logic [5:0] LAST_IDX = 6'(NUM_ROUNDS - 1);

  logic        state_q, state_d;
  logic [31:0] win_q [16];
  logic [31:0] win_d [16];
  logic [5:0]  t_q, t_d;
  logic        blk_ready_q, blk_ready_d;
  logic        last_q, last_d;
  logic [31:0] new_word;
  logic        blk_take;
  logic        w_take;

  // Small sigma functions of the SHA-256 message expansion.
  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // W[t+16] from the current window. It is always computed and is only
  // committed when a word is handed off before the last round.
  always_comb begin
    new_word = ssig1(win_q[14]) + win_q[9] + ssig0(win_q[1]) + win_q[0];
  end

  // Next-state logic for the FSM, the window, the round index and the
  // registered output flags.
  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    win_d    = win_q;
    blk_take = (state_q == IDLE) && blk_valid && blk_ready_q;
    w_take   = (state_q == RUN) && w_ready;

    if (blk_take) begin
      for (int i = 0; i < 16; i++) begin
        win_d[i] = blk_data[511 - 32*i -: 32];
      end
      t_d     = 6'd0;
      state_d = RUN;
    end else if (w_take) begin
      if (t_q == LAST_IDX) begin
        state_d = IDLE;
      end else begin
        for (int i = 0; i < 15; i++) begin
          win_d[i] = win_q[i+1];
        end
        win_d[15] = new_word;
        t_d       = t_q + 6'd1;
      end
    end

    blk_ready_d = (state_d == IDLE);
    last_d      = (state_d == RUN) && (t_d == LAST_IDX);
  end

  // State registers. Reset clears everything and abandons any block in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      t_q         <= 6'd0;
      blk_ready_q <= 1'b0;
      last_q      <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        win_q[i] <= 32'd0;
      end
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      blk_ready_q <= blk_ready_d;
      last_q      <= last_d;
      win_q       <= win_d;
    end
  end

  assign blk_ready = blk_ready_q;
  assign w_valid   = (state_q == RUN);
  assign busy      = (state_q == RUN);
  assign w_data    = win_q[0];
  assign w_idx     = t_q;
  assign w_last    = last_q;

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Testbench for sha256_msg_sched.
// The main instance uses the default 64 rounds. A second instance runs with
// 16 rounds. Expected words come from an independent reference model and are
// queued when a block is driven, then popped as the DUT hands each word off.
module tb_sha256_msg_sched;

  localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         blk_valid = 1'b0;
  logic         blk_ready;
  logic [511:0] blk_data = '0;
  logic         w_valid;
  logic         w_ready = 1'b0;
  logic [31:0]  w_data;
  logic [5:0]   w_idx;
  logic         w_last;
  logic         busy;

  logic         s_blk_valid = 1'b0;
  logic         s_blk_ready;
  logic [511:0] s_blk_data = '0;
  logic         s_w_valid;
  logic         s_w_ready = 1'b1;
  logic [31:0]  s_w_data;
  logic [5:0]   s_w_idx;
  logic         s_w_last;
  logic         s_busy;

  logic [38:0]  exp_q[$];
  int           tests_run = 0;
  int           tests_failed = 0;

  always #5 clk = ~clk;

  sha256_msg_sched dut (
    .clk(clk), .rst_n(rst_n), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .blk_data(blk_data), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .w_idx(w_idx), .w_last(w_last), .busy(busy)
  );

  sha256_msg_sched #(.NUM_ROUNDS(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .blk_valid(s_blk_valid), .blk_ready(s_blk_ready),
    .blk_data(s_blk_data), .w_valid(s_w_valid), .w_ready(s_w_ready), .w_data(s_w_data),
    .w_idx(s_w_idx), .w_last(s_w_last), .busy(s_busy)
  );

  // ---------------- reference model ----------------
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ref_s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ref_s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Queue {last, idx, data} for every word a block should produce.
  task automatic push_expected(input logic [511:0] b, input int rounds);
    logic [31:0] w [64];
    for (int t = 0; t < 16; t++) w[t] = b[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) w[t] = ref_s1(w[t-2]) + w[t-7] + ref_s0(w[t-15]) + w[t-16];
    for (int t = 0; t < rounds; t++) exp_q.push_back({(t == rounds - 1), 6'(t), w[t]});
  endtask

  // ---------------- driver ----------------
  // Present a block, wait for it to be accepted, then drop blk_valid.
  task automatic drive_block(input logic [511:0] b);
    int k;
    push_expected(b, 64);
    @(negedge clk);
    blk_data  = b;
    blk_valid = 1'b1;
    k = 0;
    while (!blk_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    tests_run++;
    if (blk_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL blk_accept_timeout: blk_ready=%b required 1", blk_ready);
    end
    @(posedge clk);
    #1 blk_valid = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    tests_run++;
    if ({blk_ready, w_valid, w_data, w_idx, w_last, busy} !== 41'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: rdy=%b vld=%b data=%h idx=%0d last=%b busy=%b required all 0",
               blk_ready, w_valid, w_data, w_idx, w_last, busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (blk_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_release_ready: blk_ready=%b required 1", blk_ready);
    end
    w_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (w_valid !== 1'b0 || w_idx !== 6'd0 || busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL idle_w_ready: vld=%b idx=%0d busy=%b required 0/0/0", w_valid, w_idx, busy);
      end
    end
    w_ready = 1'b0;
  endtask

  task automatic test_abc();
    logic [38:0] e;
    logic [31:0] got [64];
    logic [31:0] kat [6];
    int          kat_idx [6];
    logic        saw_end;
    kat = '{32'h61626380, 32'h00000018, 32'h61626380, 32'h000F0000, 32'h7DA86405, 32'h600003C6};
    kat_idx = '{0, 15, 16, 17, 18, 19};
    for (int i = 0; i < 64; i++) got[i] = 32'hDEADBEEF;
    drive_block(ABC_BLK);
    saw_end = 1'b0;
    for (int n = 0; n < 200 && !saw_end; n++) begin
      @(negedge clk);
      w_ready = 1'b1;
      if (n == 0) begin
        tests_run++;
        if (w_valid !== 1'b1 || busy !== 1'b1) begin
          tests_failed++;
          $display("FAIL abc_latency: vld=%b busy=%b required 1/1", w_valid, busy);
        end
      end
      if (w_valid) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL abc_extra_word: idx=%0d data=%h required no word", w_idx, w_data);
        end else begin
          e = exp_q.pop_front();
          if ({w_last, w_idx, w_data} !== e) begin
            tests_failed++;
            $display("FAIL abc_word: got last=%b idx=%0d data=%h required last=%b idx=%0d data=%h",
                     w_last, w_idx, w_data, e[38], e[37:32], e[31:0]);
          end
        end
        got[w_idx] = w_data;
        if (w_last) saw_end = 1'b1;
      end
    end
    tests_run++;
    if (!saw_end) begin
      tests_failed++;
      $display("FAIL abc_timeout: w_last seen=%b required 1", saw_end);
    end
    for (int i = 0; i < 6; i++) begin
      tests_run++;
      if (got[kat_idx[i]] !== kat[i]) begin
        tests_failed++;
        $display("FAIL abc_known_W%0d: got %h required %h", kat_idx[i], got[kat_idx[i]], kat[i]);
      end
    end
    @(negedge clk);
    tests_run++;
    if (blk_ready !== 1'b1 || w_valid !== 1'b0 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL abc_end: rdy=%b vld=%b left=%0d required 1/0/0", blk_ready, w_valid, exp_q.size());
    end
  endtask

  task automatic test_zero();
    logic [38:0] e;
    int          cnt;
    cnt = 0;
    drive_block(512'h0);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      w_ready = 1'b1;
      if (w_valid) begin
        cnt++;
        tests_run++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 39'h7F_FFFF_FFFF;
        if ({w_last, w_idx, w_data} !== e || w_data !== 32'd0) begin
          tests_failed++;
          $display("FAIL zero_word: got last=%b idx=%0d data=%h required last=%b idx=%0d data=%h",
                   w_last, w_idx, w_data, e[38], e[37:32], e[31:0]);
        end
      end else if (cnt > 0) begin
        break;
      end
    end
    tests_run++;
    if (cnt != 64) begin
      tests_failed++;
      $display("FAIL zero_run_length: got %0d valid cycles required 64", cnt);
    end
  endtask

  task automatic test_stall();
    logic [38:0] e;
    logic        p_valid, p_ready, p_last, saw_end;
    logic [31:0] p_data;
    logic [5:0]  p_idx;
    p_valid = 1'b0; p_ready = 1'b0; p_data = '0; p_idx = '0; p_last = 1'b0;
    saw_end = 1'b0;
    drive_block(ABC_BLK);
    for (int n = 0; n < 2000 && !saw_end; n++) begin
      @(negedge clk);
      if (p_valid && !p_ready) begin
        tests_run++;
        if (w_valid !== 1'b1 || w_data !== p_data || w_idx !== p_idx || w_last !== p_last) begin
          tests_failed++;
          $display("FAIL stall_hold: got vld=%b idx=%0d data=%h required 1 idx=%0d data=%h",
                   w_valid, w_idx, w_data, p_idx, p_data);
        end
      end
      w_ready = 1'($urandom_range(0, 1));
      if (w_valid && w_ready) begin
        tests_run++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 39'h7F_FFFF_FFFF;
        if ({w_last, w_idx, w_data} !== e) begin
          tests_failed++;
          $display("FAIL stall_word: got last=%b idx=%0d data=%h required last=%b idx=%0d data=%h",
                   w_last, w_idx, w_data, e[38], e[37:32], e[31:0]);
        end
        if (w_last) saw_end = 1'b1;
      end
      p_valid = w_valid; p_ready = w_ready; p_data = w_data; p_idx = w_idx; p_last = w_last;
    end
    tests_run++;
    if (!saw_end || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL stall_complete: end=%b left=%0d required 1/0", saw_end, exp_q.size());
    end
    @(negedge clk);
    w_ready = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [38:0]  e;
    logic [511:0] b2;
    int           words, last_n, w0_n;
    for (int i = 0; i < 16; i++) b2[32*i +: 32] = $urandom;
    words = 0; last_n = -1; w0_n = -1;
    @(negedge clk);
    w_ready   = 1'b1;
    blk_data  = ABC_BLK;
    blk_valid = 1'b1;
    push_expected(ABC_BLK, 64);
    @(posedge clk);
    #1 blk_data = b2;
    push_expected(b2, 64);
    for (int n = 0; n < 400 && words < 128; n++) begin
      @(negedge clk);
      if (w_valid) begin
        if (words == 64) begin
          w0_n = n;
          blk_valid = 1'b0;
        end
        if (words < 64 && blk_ready !== 1'b0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL b2b_ready_in_run: blk_ready=%b required 0", blk_ready);
        end
        tests_run++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 39'h7F_FFFF_FFFF;
        if ({w_last, w_idx, w_data} !== e) begin
          tests_failed++;
          $display("FAIL b2b_word: got last=%b idx=%0d data=%h required last=%b idx=%0d data=%h",
                   w_last, w_idx, w_data, e[38], e[37:32], e[31:0]);
        end
        if (w_last && words == 63) last_n = n;
        words++;
      end
    end
    tests_run++;
    if (last_n < 0 || w0_n - last_n != 2) begin
      tests_failed++;
      $display("FAIL b2b_gap: got %0d cycles from w_last to next W0 required 2", w0_n - last_n);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (w_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL b2b_no_third_block: w_valid=%b required 0", w_valid);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [38:0] e;
    logic        hit, saw_end;
    hit = 1'b0; saw_end = 1'b0;
    drive_block(ABC_BLK);
    for (int n = 0; n < 200 && !hit; n++) begin
      @(negedge clk);
      w_ready = 1'b1;
      if (w_valid && w_idx == 6'd30) hit = 1'b1;
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (!hit || {w_valid, busy, w_data, w_idx, w_last, blk_ready} !== 41'd0) begin
      tests_failed++;
      $display("FAIL async_reset: hit=%b vld=%b busy=%b data=%h idx=%0d rdy=%b required all 0",
               hit, w_valid, busy, w_data, w_idx, blk_ready);
    end
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (blk_ready !== 1'b1 || w_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_release: rdy=%b vld=%b required 1/0", blk_ready, w_valid);
    end
    drive_block(ABC_BLK);
    for (int n = 0; n < 200 && !saw_end; n++) begin
      @(negedge clk);
      if (w_valid) begin
        if (n == 0) begin
          tests_run++;
          if (w_idx !== 6'd0 || w_data !== 32'h61626380) begin
            tests_failed++;
            $display("FAIL async_fresh_w0: idx=%0d data=%h required 0 61626380", w_idx, w_data);
          end
        end
        tests_run++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 39'h7F_FFFF_FFFF;
        if ({w_last, w_idx, w_data} !== e) begin
          tests_failed++;
          $display("FAIL async_word: got last=%b idx=%0d data=%h required last=%b idx=%0d data=%h",
                   w_last, w_idx, w_data, e[38], e[37:32], e[31:0]);
        end
        if (w_last) saw_end = 1'b1;
      end
    end
    tests_run++;
    if (!saw_end) begin
      tests_failed++;
      $display("FAIL async_timeout: w_last seen=%b required 1", saw_end);
    end
  endtask

  task automatic test_short_rounds();
    logic [38:0]  e;
    logic [511:0] tmp;
    int           cnt, k;
    cnt = 0;
    tmp = ABC_BLK;
    push_expected(ABC_BLK, 16);
    @(negedge clk);
    s_blk_data  = ABC_BLK;
    s_blk_valid = 1'b1;
    k = 0;
    while (!s_blk_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1 s_blk_valid = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (s_w_valid) begin
        cnt++;
        tests_run++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 39'h7F_FFFF_FFFF;
        if ({s_w_last, s_w_idx, s_w_data} !== e ||
            s_w_data !== tmp[511 - 32*int'(s_w_idx) -: 32]) begin
          tests_failed++;
          $display("FAIL r16_word: got last=%b idx=%0d data=%h required last=%b idx=%0d data=%h",
                   s_w_last, s_w_idx, s_w_data, e[38], e[37:32], e[31:0]);
        end
      end
    end
    tests_run++;
    if (cnt != 16 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL r16_count: got %0d words (%0d left) required 16", cnt, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_zero();
    test_stall();
    test_back_to_back();
    test_async_reset();
    test_short_rounds();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
